alu_writeback: RTL

- Clocked writeback stage at the consumer end of the ALU's two-phase trigger/ready protocol.
- Requests results from the ALU, waits for them, and commits them to the register-file write port and the internal CPSR.
- Also redirects the PC on writes to R15 and counts retired instructions.
- Sits between the ALU (asynchronous producer) and the register file / fetch stage (synchronous to clk).

---
 rtl/alu_pkg.sv | 30 +++
 rtl/sync_bit.sv | 23 ++
 rtl/alu_writeback.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared field positions, CPSR flag indices and FSM state encoding for the ALU writeback slice.
package alu_pkg;

    localparam int unsigned RD_LSB   = 12;
    localparam int unsigned RN_LSB   = 16;
    localparam int unsigned S_BIT    = 20;
    localparam int unsigned WBRN_BIT = 21;

    localparam int unsigned FLAG_N = 31;
    localparam int unsigned FLAG_Z = 30;
    localparam int unsigned FLAG_C = 29;
    localparam int unsigned FLAG_V = 28;

    localparam logic [3:0] PC_INDEX = 4'd15;

    typedef enum logic [2:0] {
        StIdle,
        StWaitLow,
        StWaitHigh,
        StCapture,
        StWriteRd,
        StWriteRn,
        StCommit
    } wb_state_e;

    function automatic logic [3:0] reg_field(input logic [31:0] src_dst, input int unsigned lsb);
        return src_dst[lsb +: 4];
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser bringing one asynchronous level into the local clock domain.
module sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_ff;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ff <= '0;
        end else begin
            r_ff <= {r_ff[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[SYNC_STAGES-1];

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: requests ALU results over the toggle/ready handshake and commits them
// to the register-file write port, the PC redirect and the CPSR flags.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned RETIRE_W    = 16
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                run,
    input  logic                readyIn,
    input  logic [31:0]         dataIn1,
    input  logic [31:0]         dataIn2,
    input  logic [31:0]         cpsrIn,
    input  logic                wIn,
    input  logic [31:0]         srcDstIn,
    output logic                triggerOut,
    output logic                regWrEn,
    output logic [3:0]          regWrAddr,
    output logic [31:0]         regWrData,
    input  logic                regWrStall,
    output logic [31:0]         cpsrOut,
    output logic                pcWrEn,
    output logic [31:0]         pcWrData,
    output logic [RETIRE_W-1:0] retired,
    output logic                busy,
    output logic                error
);

    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    wb_state_e           r_state;
    wb_state_e           w_state_next;
    logic                r_trigger;
    logic                r_error;
    logic [TMO_W-1:0]    r_tmo;
    logic [31:0]         r_data1;
    logic [31:0]         r_data2;
    logic [3:0]          r_flags_in;
    logic                r_w;
    logic [3:0]          r_rd;
    logic [3:0]          r_rn;
    logic                r_s;
    logic                r_wbrn;
    logic [3:0]          r_flags;
    logic [RETIRE_W-1:0] r_retired;

    logic w_ready_sync;
    logic w_fire;
    logic w_tmo_hit;
    logic w_timeout;
    logic w_waiting;
    logic w_unused;

    sync_bit #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_ready (
        .i_clk  (clk),
        .i_rst_n(resetN),
        .i_d    (readyIn),
        .o_q    (w_ready_sync)
    );

    assign w_fire    = (r_state == StIdle) && run && !r_error;
    assign w_waiting = (r_state == StWaitLow) || (r_state == StWaitHigh);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_fire) w_state_next = StWaitLow;
            end
            StWaitLow: begin
                if (!w_ready_sync) w_state_next = StWaitHigh;
                else if (w_tmo_hit) w_timeout = 1'b1;
            end
            StWaitHigh: begin
                if (w_ready_sync) w_state_next = StCapture;
                else if (w_tmo_hit) w_timeout = 1'b1;
            end
            StCapture: begin
                if (wIn) w_state_next = StWriteRd;
                else if (srcDstIn[WBRN_BIT]) w_state_next = StWriteRn;
                else w_state_next = StCommit;
            end
            StWriteRd: begin
                if (!regWrStall) w_state_next = r_wbrn ? StWriteRn : StCommit;
            end
            StWriteRn: begin
                if (!regWrStall) w_state_next = StCommit;
            end
            StCommit: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        if (w_timeout) w_state_next = StIdle;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= StIdle;
            r_trigger  <= 1'b0;
            r_error    <= 1'b0;
            r_tmo      <= '0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_flags_in <= '0;
            r_w        <= 1'b0;
            r_rd       <= '0;
            r_rn       <= '0;
            r_s        <= 1'b0;
            r_wbrn     <= 1'b0;
            r_flags    <= '0;
            r_retired  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fire) r_trigger <= ~r_trigger;
            if (w_timeout) r_error <= 1'b1;
            // Timeout budget restarts on every state entry.
            if (w_state_next != r_state) begin
                r_tmo <= '0;
            end else if (w_waiting) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (r_state == StCapture) begin
                r_data1    <= dataIn1;
                r_data2    <= dataIn2;
                r_flags_in <= cpsrIn[FLAG_N:FLAG_V];
                r_w        <= wIn;
                r_rd       <= reg_field(srcDstIn, RD_LSB);
                r_rn       <= reg_field(srcDstIn, RN_LSB);
                r_s        <= srcDstIn[S_BIT];
                r_wbrn     <= srcDstIn[WBRN_BIT];
            end
            if (r_state == StCommit) begin
                if (r_s) r_flags <= r_flags_in;
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    always_comb begin
        regWrEn   = 1'b0;
        regWrAddr = '0;
        regWrData = '0;
        if (r_state == StWriteRd) begin
            regWrEn   = 1'b1;
            regWrAddr = r_rd;
            regWrData = r_data1;
        end else if (r_state == StWriteRn) begin
            regWrEn   = 1'b1;
            regWrAddr = r_rn;
            regWrData = r_data2;
        end
    end

    // The PC strobe fires only in the cycle the Rd write actually completes.
    assign pcWrEn     = (r_state == StWriteRd) && r_w && (r_rd == PC_INDEX) && !regWrStall;
    assign pcWrData   = pcWrEn ? r_data1 : '0;
    assign triggerOut = r_trigger;
    assign cpsrOut    = {r_flags, 28'h0};
    assign retired    = r_retired;
    assign busy       = (r_state != StIdle);
    assign error      = r_error;

    assign w_unused = ^{cpsrIn[FLAG_V-1:0], srcDstIn[31:WBRN_BIT+1], srcDstIn[RD_LSB-1:0]};

endmodule
